// File: rtl/hazard_controller.sv
// hazard_controller: decode-stage hazard detection for the 5-stage datapath.
// A private two-slot shadow pipeline (EX, MEM) remembers the destinations of
// the instructions ahead of decode. Control outputs are combinational from
// that shadow state and the decode fields. Taken branches take priority over
// stalls, because the stalled instruction is being killed anyway.
//
// Handshake note: there is no valid/ready pair here. id_valid qualifies the
// decode fields in the same cycle. branch_taken is a single-cycle strobe.
// The controls are meaningful in every cycle.
module hazard_controller #(
    parameter bit FORWARDING = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       ID_Rn,
    input  logic [4:0]       ID_Rm,
    input  logic [4:0]       ID_Rd,
    input  logic             Reg2Loc,
    input  logic             id_uses_a,
    input  logic             id_uses_b,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             stall_active,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [4:0] XZR = 5'd31;

    // Shadow pipeline slots
    logic       ex_valid;
    logic [4:0] ex_rd;
    logic       ex_reg_write;
    logic       ex_mem_read;
    logic       mem_valid;
    logic [4:0] mem_rd;
    logic       mem_reg_write;

    logic [4:0] src_b;
    logic       a_ex;
    logic       b_ex;
    logic       a_mem;
    logic       b_mem;
    logic       load_use;
    logic       raw_any;
    logic       hazard;

    assign src_b = Reg2Loc ? ID_Rm : ID_Rd;

    // Source/slot matches; XZR never creates a dependency
    assign a_ex  = id_uses_a && ex_valid && ex_reg_write && (ex_rd == ID_Rn) && (ID_Rn != XZR);
    assign b_ex  = id_uses_b && ex_valid && ex_reg_write && (ex_rd == src_b) && (src_b != XZR);
    assign a_mem = id_uses_a && mem_valid && mem_reg_write && (mem_rd == ID_Rn) && (ID_Rn != XZR);
    assign b_mem = id_uses_b && mem_valid && mem_reg_write && (mem_rd == src_b) && (src_b != XZR);

    assign load_use = id_valid && ex_mem_read && (a_ex || b_ex);
    assign raw_any  = id_valid && (a_ex || b_ex || a_mem || b_mem);
    assign hazard   = FORWARDING ? load_use : raw_any;

    // Control decision: taken branch, then hazard, then normal flow
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        idex_bubble  = 1'b0;
        ifid_flush   = 1'b0;
        stall_active = 1'b0;
        if (branch_taken) begin
            idex_bubble = 1'b1;
            ifid_flush  = 1'b1;
        end else if (hazard) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_bubble  = 1'b1;
            stall_active = 1'b1;
        end
    end

    // Shadow pipeline advance: MEM takes EX, EX takes decode unless bubbled
    always_ff @(posedge clk) begin
        if (!reset) begin
            ex_valid      <= 1'b0;
            ex_rd         <= 5'd0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            mem_valid     <= 1'b0;
            mem_rd        <= 5'd0;
            mem_reg_write <= 1'b0;
        end else begin
            mem_valid     <= ex_valid;
            mem_rd        <= ex_rd;
            mem_reg_write <= ex_reg_write;
            if (id_valid && !idex_bubble) begin
                ex_valid     <= 1'b1;
                ex_rd        <= ID_Rd;
                ex_reg_write <= id_reg_write;
                ex_mem_read  <= id_mem_read;
            end else begin
                ex_valid <= 1'b0;
            end
        end
    end

    // Saturating event counters for performance debug
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (stall_active && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + CNT_W'(1);
            end
            if (branch_taken && (flush_count != {CNT_W{1'b1}})) begin
                flush_count <= flush_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: table-driven check of two hazard_controller instances.
// dut_f uses forwarding with 16-bit counters. dut_n has no forwarding and
// 4-bit counters, so saturation is reachable. Each vector targets one
// instance while the other sees idle inputs.
module tb_hazard_controller;

    typedef struct packed {
        logic       rst_n;
        logic       v;
        logic [4:0] rd;
        logic [4:0] rn;
        logic [4:0] rm;
        logic       r2l;
        logic       ua;
        logic       ub;
        logic       rw;
        logic       mr;
        logic       br;
    } in_t;

    typedef struct {
        logic  sel;
        in_t   in;
        logic  exp_stall;
        int    exp_sc;
        int    exp_fc;
        string name;
    } vec_t;

    localparam int W = 37;

    logic clk = 1'b0;
    in_t  in_f;
    in_t  in_n;

    logic        pc_f, ifid_f, bub_f, fl_f, st_f;
    logic [15:0] sc_f, fc_f;
    logic        pc_n, ifid_n, bub_n, fl_n, st_n;
    logic [3:0]  sc_n, fc_n;

    logic [W-1:0] exp_q[$];
    vec_t         vecs[$];
    int           checks = 0;
    int           errors = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    hazard_controller #(.FORWARDING(1'b1), .CNT_W(16)) dut_f (
        .clk(clk), .reset(in_f.rst_n), .id_valid(in_f.v),
        .ID_Rn(in_f.rn), .ID_Rm(in_f.rm), .ID_Rd(in_f.rd), .Reg2Loc(in_f.r2l),
        .id_uses_a(in_f.ua), .id_uses_b(in_f.ub), .id_reg_write(in_f.rw),
        .id_mem_read(in_f.mr), .branch_taken(in_f.br),
        .pc_write(pc_f), .ifid_write(ifid_f), .idex_bubble(bub_f),
        .ifid_flush(fl_f), .stall_active(st_f),
        .stall_count(sc_f), .flush_count(fc_f)
    );

    hazard_controller #(.FORWARDING(1'b0), .CNT_W(4)) dut_n (
        .clk(clk), .reset(in_n.rst_n), .id_valid(in_n.v),
        .ID_Rn(in_n.rn), .ID_Rm(in_n.rm), .ID_Rd(in_n.rd), .Reg2Loc(in_n.r2l),
        .id_uses_a(in_n.ua), .id_uses_b(in_n.ub), .id_reg_write(in_n.rw),
        .id_mem_read(in_n.mr), .branch_taken(in_n.br),
        .pc_write(pc_n), .ifid_write(ifid_n), .idex_bubble(bub_n),
        .ifid_flush(fl_n), .stall_active(st_n),
        .stall_count(sc_n), .flush_count(fc_n)
    );

    // ---------------- helpers ----------------
    function automatic in_t mk(logic v, logic [4:0] rd, logic [4:0] rn, logic [4:0] rm,
                               logic r2l, logic ua, logic ub, logic rw, logic mr, logic br);
        in_t t;
        t.rst_n = 1'b1; t.v = v; t.rd = rd; t.rn = rn; t.rm = rm; t.r2l = r2l;
        t.ua = ua; t.ub = ub; t.rw = rw; t.mr = mr; t.br = br;
        return t;
    endfunction

    function automatic in_t idle();
        return mk(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    // {pc_write, ifid_write, idex_bubble, ifid_flush, stall_active}
    function automatic logic [4:0] ctrl_of(logic br, logic stall);
        if (br) return 5'b11110;
        if (stall) return 5'b00101;
        return 5'b11000;
    endfunction

    task automatic add(input logic sel, input in_t in, input logic stall,
                       input int sc, input int fc, input string name);
        vec_t v;
        v.sel = sel; v.in = in; v.exp_stall = stall;
        v.exp_sc = sc; v.exp_fc = fc; v.name = name;
        vecs.push_back(v);
    endtask

    // ---------------- driver + scoreboard ----------------
    task automatic run_vec(input vec_t v);
        logic [W-1:0] exp;
        logic [W-1:0] act;
        @(posedge clk);
        #1;
        if (v.sel) begin
            in_n = v.in; in_f = idle();
        end else begin
            in_f = v.in; in_n = idle();
        end
        exp_q.push_back({ctrl_of(v.in.br, v.exp_stall), 16'(v.exp_sc), 16'(v.exp_fc)});
        #3;
        if (v.sel) act = {pc_n, ifid_n, bub_n, fl_n, st_n, 12'd0, sc_n, 12'd0, fc_n};
        else       act = {pc_f, ifid_f, bub_f, fl_f, st_f, sc_f, fc_f};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", v.name);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                errors++;
                $display("FAIL %s: ctrl/sc/fc got %b/%0d/%0d expected %b/%0d/%0d", v.name,
                         act[36:32], act[31:16], act[15:0], exp[36:32], exp[31:16], exp[15:0]);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int   stalls;
        in_t  t;

        // Reset both instances
        in_f = idle(); in_f.rst_n = 1'b0;
        in_n = idle(); in_n.rst_n = 1'b0;
        @(posedge clk);
        #1;
        in_f = idle();
        in_n = idle();

        // ---- forwarding instance ----
        add(0, idle(), 0, 0, 0, "f_reset_state");
        add(0, mk(1, 5'd1, 5'd2, 5'd0, 1, 1, 0, 1, 1, 0), 0, 0, 0, "f_ldur_x1");
        add(0, mk(1, 5'd2, 5'd1, 5'd3, 1, 1, 1, 1, 0, 0), 1, 0, 0, "f_load_use_stall");
        add(0, mk(1, 5'd2, 5'd1, 5'd3, 1, 1, 1, 1, 0, 0), 0, 1, 0, "f_load_use_release");
        add(0, mk(1, 5'd4, 5'd2, 5'd2, 1, 1, 1, 1, 0, 0), 0, 1, 0, "f_alu_raw_forwarded");
        add(0, mk(1, 5'd31, 5'd4, 5'd0, 1, 1, 0, 1, 1, 0), 0, 1, 0, "f_ldur_xzr");
        add(0, mk(1, 5'd5, 5'd31, 5'd31, 1, 1, 1, 1, 0, 0), 0, 1, 0, "f_xzr_reader");
        add(0, mk(1, 5'd7, 5'd0, 5'd0, 1, 1, 0, 1, 1, 0), 0, 1, 0, "f_ldur_x7");
        add(0, mk(1, 5'd8, 5'd7, 5'd7, 1, 0, 0, 1, 1, 0), 0, 1, 0, "f_uses_flags_off");
        add(0, mk(1, 5'd9, 5'd0, 5'd8, 0, 0, 1, 0, 0, 0), 0, 1, 0, "f_reg2loc_selects_rd");
        add(0, mk(1, 5'd10, 5'd9, 5'd0, 1, 1, 0, 1, 1, 0), 0, 1, 0, "f_slot_no_reg_write");
        add(0, mk(1, 5'd10, 5'd0, 5'd0, 0, 1, 1, 0, 0, 0), 1, 1, 0, "f_stur_rd_stall");
        add(0, mk(1, 5'd10, 5'd0, 5'd0, 0, 1, 1, 0, 0, 0), 0, 2, 0, "f_stur_release");
        add(0, mk(1, 5'd11, 5'd0, 5'd0, 1, 1, 0, 1, 1, 0), 0, 2, 0, "f_ldur_x11");
        add(0, mk(0, 5'd0, 5'd11, 5'd0, 1, 1, 0, 1, 0, 0), 0, 2, 0, "f_id_invalid");
        add(0, mk(1, 5'd12, 5'd0, 5'd0, 1, 1, 0, 1, 1, 0), 0, 2, 0, "f_ldur_x12");
        add(0, mk(1, 5'd13, 5'd12, 5'd0, 1, 1, 0, 1, 0, 1), 0, 2, 0, "f_branch_over_stall");
        add(0, mk(1, 5'd13, 5'd12, 5'd0, 1, 1, 0, 1, 0, 0), 0, 2, 1, "f_after_flush");
        add(0, idle(), 0, 2, 1, "f_idle");

        // ---- no-forwarding instance ----
        add(1, mk(1, 5'd5, 5'd1, 5'd2, 1, 1, 1, 1, 0, 0), 0, 0, 0, "n_add_x5");
        add(1, mk(1, 5'd6, 5'd5, 5'd7, 1, 1, 1, 1, 0, 0), 1, 0, 0, "n_raw_ex_stall1");
        add(1, mk(1, 5'd6, 5'd5, 5'd7, 1, 1, 1, 1, 0, 0), 1, 1, 0, "n_raw_mem_stall2");
        add(1, mk(1, 5'd6, 5'd5, 5'd7, 1, 1, 1, 1, 0, 0), 0, 2, 0, "n_raw_release");
        add(1, mk(1, 5'd9, 5'd1, 5'd2, 1, 1, 1, 1, 0, 0), 0, 2, 0, "n_independent");
        add(1, mk(1, 5'd10, 5'd6, 5'd0, 1, 1, 0, 1, 0, 0), 1, 2, 0, "n_raw_mem_only");
        add(1, mk(1, 5'd10, 5'd6, 5'd0, 1, 1, 0, 1, 0, 0), 0, 3, 0, "n_mem_release");
        add(1, mk(1, 5'd11, 5'd10, 5'd0, 1, 1, 0, 1, 0, 0), 1, 3, 0, "n_stall_pre_reset");
        t = mk(1, 5'd11, 5'd10, 5'd0, 1, 1, 0, 1, 0, 0);
        t.rst_n = 1'b0;
        add(1, t, 1, 4, 0, "n_reset_in_stall");
        add(1, mk(1, 5'd11, 5'd10, 5'd0, 1, 1, 0, 1, 0, 0), 0, 0, 0, "n_after_reset");
        add(1, mk(1, 5'd12, 5'd11, 5'd0, 1, 1, 0, 1, 0, 1), 0, 0, 0, "n_branch_over_raw");
        add(1, mk(1, 5'd12, 5'd11, 5'd0, 1, 1, 0, 1, 0, 1), 0, 0, 1, "n_branch_again");
        add(1, idle(), 0, 0, 2, "n_idle");

        // Saturation: chain of dependent ALU ops, each stalls twice (20 total)
        add(1, mk(1, 5'd1, 5'd0, 5'd0, 1, 0, 0, 1, 0, 0), 0, 0, 2, "n_sat_head");
        stalls = 0;
        for (int k = 1; k <= 10; k++) begin
            for (int s = 0; s < 2; s++) begin
                add(1, mk(1, 5'(k + 1), 5'(k), 5'd0, 1, 1, 0, 1, 0, 0), 1,
                    (stalls > 15) ? 15 : stalls, 2, $sformatf("n_sat_stall_%0d_%0d", k, s));
                stalls++;
            end
            add(1, mk(1, 5'(k + 1), 5'(k), 5'd0, 1, 1, 0, 1, 0, 0), 0,
                (stalls > 15) ? 15 : stalls, 2, $sformatf("n_sat_go_%0d", k));
        end
        add(1, idle(), 0, 15, 2, "n_sat_hold");

        // Forwarding instance counters untouched by the other instance's traffic
        add(0, idle(), 0, 2, 1, "f_counters_retained");

        foreach (vecs[i]) run_vec(vecs[i]);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard controller for the 5-stage 64-bit ARM datapath. Watches the instruction currently in the decode stage, tracks the destination registers of the two instructions ahead of it in a private shadow pipeline, and drives PC/IF-ID write enables, the ID/EX bubble and the IF/ID flush. It resolves load-use and RAW stalls and taken-branch flushes. It also keeps saturating stall and flush event counters for performance debug.

## Interface
- FORWARDING, 1, 1 = EX/MEM forwarding present (stall only on load-use); 0 = stall on any RAW against EX or MEM
- CNT_W, 16, width of performance counters

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low (reset==0 at posedge clears all state)
- id_valid  input  1  decode stage holds a real instruction
- ID_Rn  input  5  Rn field, instruction[9:5]
- ID_Rm  input  5  Rm field, instruction[20:16]
- ID_Rd  input  5  Rd field, instruction[4:0]
- Reg2Loc  input  1  second read port address select: 1 = Rm, 0 = Rd (same sense as decode mux)
- id_uses_a  input  1  instruction reads port A (Rn)
- id_uses_b  input  1  instruction reads port B
- id_reg_write  input  1  instruction writes Rd
- id_mem_read  input  1  instruction is a load
- branch_taken  input  1  branch in EX resolved taken this cycle
- pc_write  output  1  PC may update
- ifid_write  output  1  IF/ID register may load
- idex_bubble  output  1  force ID/EX control to zero
- ifid_flush  output  1  clear IF/ID to NOP
- stall_active  output  1  a stall is asserted this cycle (diagnostic)
- stall_count  output  CNT_W  saturating count of stall cycles
- flush_count  output  CNT_W  saturating count of taken-branch flushes

## Operation
- Shadow pipeline: two registered slots, EX {valid, rd, reg_write, mem_read} and MEM {valid, rd, reg_write}.
- Port B source register is srcB = Reg2Loc ? ID_Rm : ID_Rd.
- Register 31 (XZR) never creates a hazard, either as source or destination.
- Match condition for a source s against a slot: the slot is valid, the slot's reg_write is 1, slot.rd == s, and s != 31. Each source counts only when its uses flag is set.
- Load-use hazard: id_valid and either source matches the EX slot with EX.mem_read=1.
- FORWARDING=0: hazard also fires on any source match against the EX slot or the MEM slot. The regfile writes in WB before the read, so WB is never a hazard.
- Decision priority, in order:
  1. branch_taken=1: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1, stall_active=0. A taken branch overrides any stall because the stalled instruction is being killed.
  2. Hazard: pc_write=0, ifid_write=0, ifid_flush=0, idex_bubble=1, stall_active=1.
  3. Otherwise: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0, stall_active=0.
- Shadow update at each posedge:
  - MEM <= EX.
  - EX <= decode fields only when id_valid=1, idex_bubble=0 and reset=1.
  - Otherwise EX.valid <= 0.
- Counters:
  - stall_count increments in each cycle with stall_active=1.
  - flush_count increments in each cycle with branch_taken=1.
  - Both hold at all-ones and never wrap.

## Timing
- All control outputs are combinational from the current shadow state and inputs, with zero-cycle latency.
- Shadow state and counters update on the rising edge.
- Reset (reset==0 at a posedge):
  - Both slots invalid, both counters 0.
  - Controls in the next cycle (with id_valid=0, branch_taken=0): pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0, stall_active=0.
- Load-use with FORWARDING=1:
  - Exactly 1 stall cycle.
  - The next cycle the load sits in MEM, and the dependent instruction proceeds.
- RAW with FORWARDING=0:
  - 2 stall cycles when the producer is in EX.
  - 1 stall cycle when the producer is in MEM.
- Reset mid-stall: the shadow clears, so the stall drops in the cycle after the reset edge.
- Simultaneous branch_taken and a hazard: the flush wins, and EX becomes invalid next cycle.
- No stall is caused by id_valid=0, by a slot with reg_write=0, or by a source flag that is 0.

## Test plan
- Load-use stall:
  - Stimulus: LDUR X1 then ADD X2,X1,X3 (ID_Rn=1, id_uses_a=1), FORWARDING=1.
  - Response: one cycle with pc_write=0, ifid_write=0, idex_bubble=1, then normal flow; stall_count=1.
- XZR exemption: load with ID_Rd=31 followed by a reader of X31 gives no stall; pc_write stays 1 throughout.
- No-forwarding RAW:
  - Stimulus: FORWARDING=0, ADD X5,... then SUB X6,X5,X7.
  - Response: 2 consecutive stall cycles, stall_count=2.
  - With one independent instruction between them: exactly 1 stall.
- Branch over stall:
  - Stimulus: load-use hazard present and branch_taken=1 in the same cycle.
  - Response: ifid_flush=1, idex_bubble=1, pc_write=1, stall_active=0; next cycle no stall; flush_count=1.
- Reset mid-operation:
  - Stimulus: assert reset=0 during a FORWARDING=0 stall.
  - Response: after the edge, the stall drops and both counters read 0.
- Counter saturation:
  - Stimulus: CNT_W=4 with 20 continuous stall cycles (FORWARDING=0, hold the hazard).
  - Response: stall_count holds at 15 with no wrap.
